afu_rd_arbiter: RTL and testbench

- Shares the single MPF c0 read-request channel between N_REQ requester engines inside the AFU.
- Each requester presents one cache-line read per handshake as a byte address. The arbiter grants round-robin and converts the address to a cache-line address.
- It tags each header's mdata with the requester id and a sequence number, issues the header through a registered output stage, and routes c0 read responses back by tag.
- It enforces a per-requester outstanding-read limit and provides a run/drain control FSM so software can quiesce reads before a reconfigure.

---
 rtl/afu_rd_arbiter_pkg.sv | 63 ++++++
 rtl/afu_rd_arbiter_rr_arbiter.sv | 57 +++++
 rtl/afu_rd_arbiter.sv | 176 +++++++++++++++++
 tb/tb_afu_rd_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afu_rd_arbiter_pkg.sv
// Shared types and helpers for the AFU c0 read path: address conversion,
// MPF read-header construction and mdata tag decoding.
package afu_rd_arbiter_pkg;

    localparam int CL_ADDR_W     = 42;
    localparam int BYTE_ADDR_W   = CL_ADDR_W + 6;
    localparam int MDATA_ID_BITS = 2;
    localparam logic [15:0] MDATA_ID_MASK = 16'((1 << MDATA_ID_BITS) - 1);

    typedef logic [BYTE_ADDR_W-1:0] t_byteAddr;
    typedef logic [CL_ADDR_W-1:0]   t_clAddr;
    typedef logic [1:0]             t_rr_ptr;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } t_rd_state;

    typedef enum logic [3:0] {
        eREQ_RDLINE_L = 4'h0,
        eREQ_RDLINE_S = 4'h1,
        eREQ_RDLINE_I = 4'h2
    } t_cci_c0_req;

    typedef struct packed {
        logic        addrIsVirtual;
        logic        mapVAtoPhysChannel;
        logic        checkLoadStoreOrder;
        logic [1:0]  vc_sel;
        logic [1:0]  cl_len;
        t_cci_c0_req req_type;
        t_clAddr     address;
        logic [15:0] mdata;
    } t_cci_mpf_c0_ReqMemHdr;

    function automatic t_clAddr byteAddrToClAddr(input t_byteAddr addr);
        return addr[BYTE_ADDR_W-1:6];
    endfunction

    // Virtual address with MPF channel mapping (keeps VA-level ordering);
    // no load/store order check on reads.
    function automatic t_cci_mpf_c0_ReqMemHdr mkRdHdr(input t_byteAddr addr,
                                                      input logic [15:0] id,
                                                      input logic [15:0] seq);
        t_cci_mpf_c0_ReqMemHdr h;
        h                     = '0;
        h.addrIsVirtual       = 1'b1;
        h.mapVAtoPhysChannel  = 1'b1;
        h.checkLoadStoreOrder = 1'b0;
        h.vc_sel              = 2'd0;
        h.cl_len              = 2'd0;
        h.req_type            = eREQ_RDLINE_I;
        h.address             = byteAddrToClAddr(addr);
        h.mdata               = (seq << MDATA_ID_BITS) | (id & MDATA_ID_MASK);
        return h;
    endfunction

    function automatic logic [MDATA_ID_BITS-1:0] mdataId(input logic [15:0] mdata);
        return mdata[MDATA_ID_BITS-1:0];
    endfunction

endpackage

// File: rtl/afu_rd_arbiter_rr_arbiter.sv
// N-input round-robin arbiter: combinational one-hot grant searched from a
// registered pointer that advances past each winner.
module rr_arbiter
    import afu_rd_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o,
    output t_rr_ptr      grant_idx_o,
    output logic         grant_valid_o
);

    t_rr_ptr ptr_q;
    t_rr_ptr ptr_d;

    // First requester at or after the pointer wins.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!grant_valid_o && (j == ((int'(ptr_q) + k) % N)) && req_i[j]) begin
                    grant_o[j]    = 1'b1;
                    grant_idx_o   = t_rr_ptr'(j);
                    grant_valid_o = 1'b1;
                end else begin
                    grant_valid_o = grant_valid_o;
                end
            end
        end
    end

    // Next pointer: one past the winner, holding when nothing is granted.
    always_comb begin
        if (!grant_valid_o) begin
            ptr_d = ptr_q;
        end else if (int'(grant_idx_o) == N - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_idx_o + 2'd1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/afu_rd_arbiter.sv
// Shares the MPF c0 read channel among N_REQ engines: round-robin grant,
// tagged header issue, per-requester in-flight limit and response routing.
module afu_rd_arbiter
    import afu_rd_arbiter_pkg::*;
#(
    parameter int N_REQ           = 2,
    parameter int MAX_OUTSTANDING = 32,
    parameter int ID_BITS         = MDATA_ID_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flush,
    output logic                          drain_done,
    output logic                          busy,
    input  logic [N_REQ-1:0]              req_valid,
    input  t_byteAddr [N_REQ-1:0]         req_addr,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          c0_almost_full,
    output logic                          c0_req_valid,
    output t_cci_mpf_c0_ReqMemHdr         c0_req_hdr,
    input  logic                          c0_rsp_valid,
    input  logic [15:0]                   c0_rsp_mdata,
    input  logic [511:0]                  c0_rsp_data,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [511:0]                  rsp_data,
    output logic [N_REQ-1:0][$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                          err_unaligned
);

    localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SEQ_BITS = 16 - ID_BITS;

    t_rd_state                          state_q;
    logic                               busy_q;
    logic                               drain_done_q;
    logic [N_REQ-1:0]                   eligible_s;
    logic [N_REQ-1:0]                   grant_s;
    t_rr_ptr                            grant_idx_s;
    logic                               grant_any_s;
    t_byteAddr                          sel_addr_s;
    logic [SEQ_BITS-1:0]                sel_seq_s;
    logic [N_REQ-1:0]                   rsp_hit_s;
    logic [N_REQ-1:0][CNT_W-1:0]        cnt_q;
    logic [N_REQ-1:0][CNT_W-1:0]        cnt_d;
    logic [N_REQ-1:0][SEQ_BITS-1:0]     seq_q;
    logic                               issue_valid_q;
    t_cci_mpf_c0_ReqMemHdr              hdr_q;
    logic [N_REQ-1:0]                   rsp_valid_q;
    logic [511:0]                       rsp_data_q;
    logic                               err_q;

    // Eligibility, winner payload selection (grant is one-hot) and response decode.
    always_comb begin
        eligible_s = '0;
        sel_addr_s = '0;
        sel_seq_s  = '0;
        rsp_hit_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible_s[i] = (state_q == S_RUN) && !c0_almost_full && req_valid[i] &&
                            (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
            sel_addr_s    = sel_addr_s | (req_addr[i] & {BYTE_ADDR_W{grant_s[i]}});
            sel_seq_s     = sel_seq_s | (seq_q[i] & {SEQ_BITS{grant_s[i]}});
            rsp_hit_s[i]  = c0_rsp_valid && (int'(mdataId(c0_rsp_mdata)) == i);
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk           (clk),
        .reset         (reset),
        .req_i         (eligible_s),
        .grant_o       (grant_s),
        .grant_idx_o   (grant_idx_s),
        .grant_valid_o (grant_any_s)
    );

    // Same-cycle grant and response cancel; a response at zero never underflows.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i] && rsp_hit_s[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (grant_s[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (rsp_hit_s[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Control FSM with registered busy and drain_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((cnt_q == '0) && !issue_valid_q) begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        drain_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Issue stage and per-requester bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            hdr_q         <= '0;
            cnt_q         <= '0;
            seq_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            issue_valid_q <= grant_any_s;
            if (grant_any_s) begin
                hdr_q <= mkRdHdr(sel_addr_s, 16'(grant_idx_s), 16'(sel_seq_s));
            end
            cnt_q <= cnt_d;
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_s[i]) begin
                    seq_q[i] <= seq_q[i] + SEQ_BITS'(1);
                end
            end
            err_q <= err_q | (grant_any_s && (sel_addr_s[5:0] != 6'd0));
        end
    end

    // Response routing; ids at or above N_REQ never match and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_hit_s;
            if (c0_rsp_valid) begin
                rsp_data_q <= c0_rsp_data;
            end
        end
    end

    assign req_ready     = grant_s;
    assign c0_req_valid  = issue_valid_q;
    assign c0_req_hdr    = hdr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign outstanding   = cnt_q;
    assign err_unaligned = err_q;
    assign busy          = busy_q;
    assign drain_done    = drain_done_q;

endmodule

// File: tb/tb_afu_rd_arbiter.sv
// Self-checking bench for afu_rd_arbiter: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_afu_rd_arbiter;
    import afu_rd_arbiter_pkg::*;

    localparam int N    = 2;
    localparam int MAXO = 32;
    localparam int CW   = 6;

    logic                  clk;
    logic                  reset;
    logic                  enable;
    logic                  flush;
    logic                  drain_done;
    logic                  busy;
    logic [N-1:0]          req_valid;
    t_byteAddr [N-1:0]     req_addr;
    logic [N-1:0]          req_ready;
    logic                  c0_almost_full;
    logic                  c0_req_valid;
    t_cci_mpf_c0_ReqMemHdr c0_req_hdr;
    logic                  c0_rsp_valid;
    logic [15:0]           c0_rsp_mdata;
    logic [511:0]          c0_rsp_data;
    logic [N-1:0]          rsp_valid;
    logic [511:0]          rsp_data;
    logic [N-1:0][CW-1:0]  outstanding;
    logic                  err_unaligned;

    afu_rd_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAXO), .ID_BITS(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .drain_done(drain_done), .busy(busy),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .c0_almost_full(c0_almost_full), .c0_req_valid(c0_req_valid),
        .c0_req_hdr(c0_req_hdr), .c0_rsp_valid(c0_rsp_valid),
        .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .outstanding(outstanding), .err_unaligned(err_unaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 idle, 1 running, 2 draining.
    int           m_mode;
    int           m_ptr;
    int           m_cnt [N];
    int           m_seq [N];
    bit           m_iss;
    longint       m_iss_cl;
    int           m_iss_mdata;
    int           m_rsp_mask;
    logic [511:0] m_rsp_data;
    bit           m_busy, m_done, m_err;
    int           inflight[$];
    int           obs_grant;
    int           done_count;

    task automatic model_zero();
        m_mode = 0; m_ptr = 0; m_iss = 0; m_iss_cl = 0; m_iss_mdata = 0;
        m_rsp_mask = 0; m_rsp_data = '0; m_busy = 0; m_done = 0; m_err = 0;
        for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_seq[i] = 0; end
        inflight.delete();
    endtask

    task automatic drive_idle();
        enable = 1'b0; flush = 1'b0; c0_almost_full = 1'b0; c0_rsp_valid = 1'b0;
        c0_rsp_mdata = 16'h0; c0_rsp_data = '0; req_valid = '0;
        for (int i = 0; i < N; i++) req_addr[i] = '0;
    endtask

    task automatic respond_idx(input int idx);
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = 16'(inflight[idx]);
        c0_rsp_data  = {16{$urandom()}};
        inflight.delete(idx);
    endtask

    // One clock: compare every output against the model, then advance the model.
    task automatic step();
        int g;
        int ns;
        int id;
        bit hit;
        @(negedge clk);
        tests++; if (c0_req_valid !== m_iss) begin fails++; $display("FAIL c0_req_valid: got %0b want %0b", c0_req_valid, m_iss); end
        if (m_iss) begin
            tests++; if (c0_req_hdr.address !== m_iss_cl[CL_ADDR_W-1:0]) begin fails++; $display("FAIL hdr_address: got %0h want %0h", c0_req_hdr.address, m_iss_cl); end
            tests++; if (c0_req_hdr.mdata !== 16'(m_iss_mdata)) begin fails++; $display("FAIL hdr_mdata: got %0h want %0h", c0_req_hdr.mdata, m_iss_mdata); end
            tests++; if (c0_req_hdr.req_type !== eREQ_RDLINE_I || c0_req_hdr.addrIsVirtual !== 1'b1 || c0_req_hdr.checkLoadStoreOrder !== 1'b0) begin
                fails++; $display("FAIL hdr_fields: got type %0h va %0b clso %0b want 2 1 0", c0_req_hdr.req_type, c0_req_hdr.addrIsVirtual, c0_req_hdr.checkLoadStoreOrder);
            end
        end
        tests++; if (rsp_valid !== N'(m_rsp_mask)) begin fails++; $display("FAIL rsp_valid: got %0b want %0b", rsp_valid, m_rsp_mask); end
        if (m_rsp_mask != 0) begin
            tests++; if (rsp_data !== m_rsp_data) begin fails++; $display("FAIL rsp_data: got %0h want %0h", rsp_data[63:0], m_rsp_data[63:0]); end
        end
        for (int i = 0; i < N; i++) begin
            tests++; if (outstanding[i] !== CW'(m_cnt[i])) begin fails++; $display("FAIL outstanding[%0d]: got %0d want %0d", i, outstanding[i], m_cnt[i]); end
        end
        tests++; if (busy !== m_busy) begin fails++; $display("FAIL busy: got %0b want %0b", busy, m_busy); end
        tests++; if (drain_done !== m_done) begin fails++; $display("FAIL drain_done: got %0b want %0b", drain_done, m_done); end
        tests++; if (err_unaligned !== m_err) begin fails++; $display("FAIL err_unaligned: got %0b want %0b", err_unaligned, m_err); end
        g = -1;
        if (m_mode == 1 && !c0_almost_full) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N] && m_cnt[(m_ptr + k) % N] < MAXO) g = (m_ptr + k) % N;
            end
        end
        tests++; if (req_ready !== ((g < 0) ? N'(0) : N'(1 << g))) begin fails++; $display("FAIL req_ready: got %0b want grant of %0d", req_ready, g); end
        obs_grant = -1;
        for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) obs_grant = i;
        if (drain_done === 1'b1) done_count++;
        @(posedge clk);
        if (reset) begin
            model_zero();
        end else begin
            ns = m_mode;
            m_done = 0;
            if (m_mode == 0 && enable) ns = 1;
            else if (m_mode == 1 && flush) ns = 2;
            else if (m_mode == 2 && m_cnt[0] == 0 && m_cnt[1] == 0 && !m_iss) begin ns = 0; m_done = 1; end
            m_iss = (g >= 0);
            if (g >= 0) begin
                m_iss_cl    = longint'(req_addr[g]) >> 6;
                m_iss_mdata = (m_seq[g] << 2) | g;
                inflight.push_back(m_iss_mdata);
                m_seq[g]    = (m_seq[g] + 1) % 16384;
                m_ptr       = (g + 1) % N;
                if (req_addr[g][5:0] != 6'd0) m_err = 1;
            end
            m_rsp_mask = 0;
            hit = 0;
            if (c0_rsp_valid) begin
                id = int'(c0_rsp_mdata) % 4;
                if (id < N) begin
                    m_rsp_mask = 1 << id;
                    m_rsp_data = c0_rsp_data;
                    hit = (id == g);
                    if (!hit && m_cnt[id] > 0) m_cnt[id]--;
                end
            end
            if (g >= 0 && !hit) m_cnt[g]++;
            m_mode = ns;
            m_busy = (ns != 0);
        end
        #1;
    endtask

    task automatic init_run();
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        model_zero();
        step();
        reset = 1'b0; enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1; req_valid = '1; enable = 1'b1;
        @(posedge clk); #1;
        model_zero();
        step(); step();
        reset = 1'b0; enable = 1'b0; req_valid = '0;
        step();
    endtask

    task automatic test_basic();
        init_run();
        req_valid = 2'b01; req_addr[0] = 48'h1000;
        step();
        tests++; if (obs_grant != 0) begin fails++; $display("FAIL basic_grant: got %0d want 0", obs_grant); end
        req_valid = 2'b00;
        tests++; if (c0_req_valid !== 1'b1 || c0_req_hdr.address !== 42'h40 || c0_req_hdr.mdata !== 16'h0 || outstanding[0] !== 6'd1) begin
            fails++; $display("FAIL basic_issue: got v%0b a%0h m%0h o%0d want v1 a40 m0 o1", c0_req_valid, c0_req_hdr.address, c0_req_hdr.mdata, outstanding[0]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int exp_m;
        init_run();
        req_valid = 2'b11; req_addr[0] = 48'h2000; req_addr[1] = 48'h3040;
        for (int k = 0; k < 6; k++) begin
            step();
            tests++; if (obs_grant != (k % 2)) begin fails++; $display("FAIL b2b_order[%0d]: got %0d want %0d", k, obs_grant, k % 2); end
            exp_m = ((k / 2) << 2) | (k % 2);
            tests++; if (c0_req_hdr.mdata !== 16'(exp_m)) begin fails++; $display("FAIL b2b_mdata[%0d]: got %0h want %0h", k, c0_req_hdr.mdata, exp_m); end
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_limit();
        init_run();
        req_valid = 2'b10;
        for (int k = 0; k < 32; k++) begin
            req_addr[1] = t_byteAddr'(48'h10000 + 48'(k) * 48'h40);
            step();
        end
        tests++; if (outstanding[1] !== 6'd32) begin fails++; $display("FAIL limit_count: got %0d want 32", outstanding[1]); end
        step();
        tests++; if (obs_grant != -1) begin fails++; $display("FAIL limit_33rd: got %0d want -1", obs_grant); end
        c0_rsp_valid = 1'b1; c0_rsp_mdata = 16'h0001; c0_rsp_data = {16{32'hA5A5_0001}};
        inflight.delete(0);
        step();
        c0_rsp_valid = 1'b0;
        tests++; if (outstanding[1] !== 6'd31) begin fails++; $display("FAIL limit_after_rsp: got %0d want 31", outstanding[1]); end
        step();
        tests++; if (obs_grant != 1) begin fails++; $display("FAIL limit_regrant: got %0d want 1", obs_grant); end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_almost_full();
        init_run();
        req_valid = 2'b11; req_addr[0] = 48'h5000; req_addr[1] = 48'h6000;
        step();
        c0_almost_full = 1'b1;
        tests++; if (c0_req_valid !== 1'b1) begin fails++; $display("FAIL af_prior_issue: got %0b want 1", c0_req_valid); end
        for (int k = 0; k < 5; k++) begin
            step();
            tests++; if (obs_grant != -1) begin fails++; $display("FAIL af_no_grant[%0d]: got %0d want -1", k, obs_grant); end
        end
        c0_almost_full = 1'b0;
        step();
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_drain();
        init_run();
        done_count = 0;
        req_valid = 2'b11; req_addr[0] = 48'h7000; req_addr[1] = 48'h8000;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) respond_idx(0);
            step();
            c0_rsp_valid = 1'b0;
            tests++; if (obs_grant != -1) begin fails++; $display("FAIL drain_no_grant[%0d]: got %0d want -1", k, obs_grant); end
        end
        for (int k = 0; k < 6; k++) step();
        tests++; if (done_count != 1) begin fails++; $display("FAIL drain_done_count: got %0d want 1", done_count); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL drain_busy: got %0b want 0", busy); end
        req_valid = 2'b00;
    endtask

    task automatic test_unaligned_bad_id();
        init_run();
        req_valid = 2'b01; req_addr[0] = 48'h1004;
        step();
        req_valid = 2'b00;
        step();
        tests++; if (err_unaligned !== 1'b1 || c0_req_hdr.address !== 42'h40) begin
            fails++; $display("FAIL unaligned: got err %0b addr %0h want 1 40", err_unaligned, c0_req_hdr.address);
        end
        c0_rsp_valid = 1'b1; c0_rsp_mdata = 16'h0003; c0_rsp_data = {16{32'hDEAD_0003}};
        step();
        c0_rsp_valid = 1'b0;
        tests++; if (rsp_valid !== 2'b00 || outstanding[0] !== 6'd1 || outstanding[1] !== 6'd0) begin
            fails++; $display("FAIL bad_id_drop: got rv %0b o0 %0d o1 %0d want 0 1 0", rsp_valid, outstanding[0], outstanding[1]);
        end
        for (int k = 0; k < 3; k++) step();
        tests++; if (err_unaligned !== 1'b1) begin fails++; $display("FAIL unaligned_sticky: got %0b want 1", err_unaligned); end
    endtask

    task automatic test_random();
        t_byteAddr a;
        init_run();
        for (int c = 0; c < 3000; c++) begin
            enable         = ($urandom_range(0, 3) == 0);
            flush          = ($urandom_range(0, 40) == 0);
            c0_almost_full = ($urandom_range(0, 7) == 0);
            reset          = ($urandom_range(0, 999) == 0);
            req_valid      = N'($urandom());
            for (int i = 0; i < N; i++) begin
                a = t_byteAddr'({$urandom(), $urandom()});
                if ($urandom_range(0, 15) != 0) a[5:0] = 6'd0;
                req_addr[i] = a;
            end
            c0_rsp_valid = 1'b0;
            if (inflight.size() > 0 && $urandom_range(0, 2) != 0) respond_idx($urandom_range(0, inflight.size() - 1));
            step();
        end
        drive_idle();
        reset = 1'b0;
        step();
    endtask

    initial begin
        done_count = 0;
        model_zero();
        test_reset();
        test_basic();
        test_back_to_back();
        test_limit();
        test_almost_full();
        test_drain();
        test_unaligned_bad_id();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
